bus_reg_file: RTL and testbench
===============================

BUS_REG_FILE -- requirements
Module: bus_reg_file

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 32, number of registers; SHALL be a power of two and at least 2.
REQ-003 Parameter ADDR_W, default 32, request address width; SHALL be at least $clog2(DEPTH).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_write  input  1  1 means write, 0 means read.
REQ-009 req_addr  input  ADDR_W  register index.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_strb  input  DATA_W/8  byte-enable mask for writes.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_rdata  output  DATA_W  read data.
REQ-015 resp_err  output  1  address was out of range.
REQ-016 resp_write  output  1  echoes req_write of the request being answered.

Function
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-018 req_ready SHALL equal (!resp_valid || resp_ready), combinationally.
REQ-019 The response to an accepted request SHALL be valid on the next cycle (latency 1), so sustained throughput is 1 request per cycle.
REQ-020 Response state: EMPTY (resp_valid=0) or FULL (resp_valid=1).
- EMPTY -> FULL on accept.
- FULL -> FULL on accept with resp_ready=1; the new response replaces the old one.
- FULL -> EMPTY on resp_ready=1 with no accept.
- FULL holds on resp_ready=0.
REQ-021 While FULL and resp_ready=0, resp_rdata, resp_err and resp_write SHALL stay stable.
REQ-022 An address is in range if req_addr < DEPTH; the register index SHALL be req_addr[$clog2(DEPTH)-1:0].
REQ-023 In-range write: at the accept edge, each byte b with req_strb[b]=1 SHALL take req_wdata byte b; bytes with req_strb[b]=0 SHALL keep their value.
- Response: resp_err=0, resp_rdata=0.
REQ-024 In-range read: resp_rdata SHALL be the register contents at the accept edge, with resp_err=0.
REQ-025 A read accepted the cycle after a write to the same index SHALL return the newly written value.
REQ-026 Out-of-range request: no register SHALL change; the response SHALL be resp_err=1, resp_rdata=0.
REQ-027 A write with req_strb=0 SHALL change nothing and SHALL still produce a response with resp_err=0.
REQ-028 While req_valid=0 or req_ready=0, no register SHALL change.

Reset
REQ-029 While rst_n=0 at a rising edge:
- all DEPTH registers SHALL clear to 0;
- resp_valid, resp_rdata, resp_err and resp_write SHALL clear to 0.
REQ-030 Reset asserted while a response is pending SHALL discard that response; it is never delivered.
REQ-031 No request SHALL be accepted on an edge where rst_n=0; req_ready MAY be high during reset, but it has no effect.

Structure
REQ-032 Package bus_reg_file_pkg SHALL hold:
- the default values of DATA_W, DEPTH and ADDR_W;
- a pure function that merges write data into a word under a byte-strobe mask.
REQ-033 Parameter legality (DATA_W%8==0, DEPTH a power of two and at least 2, ADDR_W >= $clog2(DEPTH)) SHALL be checked at elaboration and SHALL be a fatal error if violated.
REQ-034 No sub-module; storage, response register and control SHALL be in a single module.

Verification
REQ-035 Reset, then read indices 0..31 -> each response resp_rdata=0x00000000, resp_err=0.
REQ-036 Write addr 5, data 0xDEADBEEF, strb 0xF; then write addr 5, data 0x11223344, strb 0x5; then read 5 -> 0xDE22BE44.
REQ-037 Back-to-back requests, one per cycle, resp_ready=1: write addr 7 = 0xA5A5A5A5, then read 7 next cycle -> resp_valid on both following cycles; read returns 0xA5A5A5A5.
REQ-038 Read addr 32 and write addr 0x100 (DEPTH=32) -> resp_err=1, resp_rdata=0; afterwards all registers are unchanged.
REQ-039 Hold resp_ready=0 for 3 cycles with a read of addr 3 (value 0x0000CAFE) pending -> req_ready=0, response held stable at 0x0000CAFE, no new accept; resp_ready=1 -> delivered once, req_ready=1.
REQ-040 Write addr 9 = 0x12345678, then pull rst_n low for 1 cycle while its response is pending -> resp_valid=0 next cycle; a subsequent read of 9 -> 0x00000000.

Source files
------------

// File: rtl/bus_reg_file_pkg.sv
// Shared defaults, response-state encoding and the byte-strobe merge helper
// used by the bus register file.
package bus_reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 32;

  // Widest data word the merge helper supports; narrower words are zero-extended in.
  localparam int MAX_DATA_W = 1024;

  typedef logic [MAX_DATA_W-1:0]   word_t;
  typedef logic [MAX_DATA_W/8-1:0] strb_t;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_t;

  function automatic word_t strb_merge(input word_t old_word, input word_t new_word,
                                       input strb_t strb);
    word_t merged;
    merged = old_word;
    for (int b = 0; b < MAX_DATA_W / 8; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bus_reg_file.sv
// Byte-strobed register file behind a valid/ready request port with a
// single-entry response register (latency 1, one request per cycle).
module bus_reg_file
  import bus_reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                resp_write
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $fatal(1, "bus_reg_file: DATA_W must be a non-zero multiple of 8 within MAX_DATA_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "bus_reg_file: DEPTH must be a power of two and at least 2");
  end
  if (ADDR_W < IDX_W) begin : g_bad_addr_w
    $fatal(1, "bus_reg_file: ADDR_W must be at least clog2(DEPTH)");
  end

  logic [DATA_W-1:0] regs [DEPTH];
  resp_state_t       state_p1;
  logic              accept_p0;
  logic              in_range_p0;
  logic [IDX_W-1:0]  idx_p0;

  // ---- Stage p0: request decode ----
  assign req_ready = (state_p1 == RESP_EMPTY) || resp_ready;
  assign accept_p0 = req_valid && req_ready;
  assign idx_p0    = req_addr[IDX_W-1:0];

  // Any set bit above the index field puts the address at or beyond DEPTH.
  if (ADDR_W > IDX_W) begin : g_range
    assign in_range_p0 = (req_addr[ADDR_W-1:IDX_W] == '0);
  end else begin : g_full_range
    assign in_range_p0 = 1'b1;
  end

  // ---- Stage p1: storage update and response register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1   <= RESP_EMPTY;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_write <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (accept_p0) begin
      state_p1   <= RESP_FULL;
      resp_write <= req_write;
      resp_err   <= !in_range_p0;
      resp_rdata <= (in_range_p0 && !req_write) ? regs[idx_p0] : '0;
      if (in_range_p0 && req_write) begin
        regs[idx_p0] <= DATA_W'(strb_merge(word_t'(regs[idx_p0]), word_t'(req_wdata),
                                           strb_t'(req_strb)));
      end
    end else if (resp_ready) begin
      state_p1 <= RESP_EMPTY;
    end
  end

  assign resp_valid = (state_p1 == RESP_FULL);

endmodule

// File: tb/tb_bus_reg_file.sv
// Self-checking bench for bus_reg_file: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_bus_reg_file;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_strb;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic                resp_write;

  bus_reg_file #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .resp_write (resp_write)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  // One request with resp_ready=1; the response is checked one cycle later.
  // Leaves req_valid high so consecutive calls form back-to-back traffic.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] got);
    logic        in_rng;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_strb   = s;
    resp_ready = 1'b1;
    #1;
    check($sformatf("req_ready a=%0h", a), {31'b0, req_ready}, 32'd1);
    in_rng = (a < DEPTH);
    exp_rd = (in_rng && !w) ? model[a] : 32'h0;
    if (in_rng && w) begin
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) mask = mask + (32'hFF << (8 * b));
      model[a] = (model[a] & ~mask) | (d & mask);
    end
    @(posedge clk);
    #1;
    check($sformatf("resp_valid a=%0h", a), {31'b0, resp_valid}, 32'd1);
    check($sformatf("resp_rdata a=%0h", a), resp_rdata, exp_rd);
    check($sformatf("resp_err a=%0h", a), {31'b0, resp_err}, {31'b0, !in_rng});
    check($sformatf("resp_write a=%0h", a), {31'b0, resp_write}, {31'b0, w});
    got = resp_rdata;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; resp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", {31'b0, resp_err}, 32'd0);
    check("reset resp_write", {31'b0, resp_write}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All registers read back zero after reset, issued back-to-back.
    for (int i = 0; i < DEPTH; i++) issue(1'b0, i, 32'h0, 4'h0, got);
    idle();

    // Byte-strobe merge.
    issue(1'b1, 5, 32'hDEADBEEF, 4'hF, got);
    issue(1'b1, 5, 32'h11223344, 4'h5, got);
    issue(1'b0, 5, 32'h0, 4'h0, got);
    check("strb merge addr5", got, 32'hDE22BE44);
    issue(1'b1, 5, 32'hFFFFFFFF, 4'h0, got);
    issue(1'b0, 5, 32'h0, 4'h0, got);
    check("zero strb keeps addr5", got, 32'hDE22BE44);
    idle();

    // Read immediately after write to the same index.
    issue(1'b1, 7, 32'hA5A5A5A5, 4'hF, got);
    issue(1'b0, 7, 32'h0, 4'h0, got);
    check("raw addr7", got, 32'hA5A5A5A5);
    idle();

    // Out-of-range accesses leave storage untouched.
    issue(1'b0, 32, 32'h0, 4'h0, got);
    issue(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, got);
    issue(1'b1, 32'h8000_0005, 32'h0BADBAD0, 4'hF, got);
    for (int i = 0; i < DEPTH; i++) issue(1'b0, i, 32'h0, 4'h0, got);
    idle();

    // Response held under back-pressure.
    issue(1'b1, 3, 32'h0000CAFE, 4'hF, got);
    idle();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 3; resp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_wdata = 32'hFFFFFFFF; req_strb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d resp_valid", c), {31'b0, resp_valid}, 32'd1);
      check($sformatf("stall%0d resp_rdata", c), resp_rdata, 32'h0000CAFE);
      check($sformatf("stall%0d resp_write", c), {31'b0, resp_write}, 32'd0);
      check($sformatf("stall%0d req_ready", c), {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    #1;
    check("unstall req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("delivered once", {31'b0, resp_valid}, 32'd0);
    issue(1'b0, 3, 32'h0, 4'h0, got);
    check("blocked write ignored", got, 32'h0000CAFE);

    // Reset while a response is pending; a request during reset is ignored.
    issue(1'b1, 9, 32'h12345678, 4'hF, got);
    @(negedge clk);
    rst_n = 1'b0; resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 1; req_wdata = 32'hFFFFFFFF; req_strb = 4'hF;
    @(posedge clk);
    #1;
    check("reset drops resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    model_reset();
    issue(1'b0, 9, 32'h0, 4'h0, got);
    check("addr9 after reset", got, 32'h0);
    issue(1'b0, 1, 32'h0, 4'h0, got);
    check("no accept in reset", got, 32'h0);
    idle();

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1, 2:    a = $urandom_range(DEPTH, DEPTH + 8);
        default: a = $urandom_range(0, DEPTH - 1);
      endcase
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), got);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    for (int i = 0; i < DEPTH; i++) issue(1'b0, i, 32'h0, 4'h0, got);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
